// File: rtl/pill_event_scheduler_pkg.sv
// Shared definitions for the pill/power/ghost event scheduler:
// collision codes, point values, FSM state encoding and scoring helpers.
package pill_event_scheduler_pkg;

    localparam logic [3:0]  COL_PILL  = 4'b0010;
    localparam logic [3:0]  COL_POWER = 4'b0110;
    localparam logic [3:0]  COL_GHOST = 4'b0100;

    localparam logic [11:0] PTS_PILL  = 12'd10;
    localparam logic [11:0] PTS_POWER = 12'd50;
    localparam logic [11:0] PTS_GHOST = 12'd200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the three collision codes that represent a scoring event.
    function automatic logic col_valid(input logic [3:0] code);
        return (code == COL_PILL) || (code == COL_POWER) || (code == COL_GHOST);
    endfunction

    // Ghost value doubles with each ghost eaten in one power period: 200/400/800/1600.
    function automatic logic [11:0] ghost_points(input logic [1:0] chain);
        return PTS_GHOST << chain;
    endfunction

endpackage

// File: rtl/pill_event_scheduler_if.sv
// Bundle of collision-detector inputs and scheduler outputs.
// master = collision/game side, slave = the scheduler.
interface pill_event_scheduler_if;

    logic [3:0]  collision_type;
    logic        level_restart;
    logic        pill_inc;
    logic        score_valid;
    logic [11:0] score_add;
    logic        power_active;
    logic        pacman_hit;
    logic [7:0]  pill_count;
    logic        level_done;
    logic        overflow;

    modport master (
        output collision_type, level_restart,
        input  pill_inc, score_valid, score_add, power_active,
               pacman_hit, pill_count, level_done, overflow
    );

    modport slave (
        input  collision_type, level_restart,
        output pill_inc, score_valid, score_add, power_active,
               pacman_hit, pill_count, level_done, overflow
    );

endinterface

// File: rtl/pill_event_scheduler_power_timer.sv
// Power-mode down-counter plus ghost-chain counter. A pellet reloads the
// timer and restarts the chain; the chain also clears when the timer expires.
module power_timer
    import pill_event_scheduler_pkg::*;
#(
    parameter logic [23:0] POWER_CYCLES = 24'd10_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       load,
    input  logic       ghost_inc,
    output logic       power_active,
    output logic [1:0] chain
);

    logic [23:0] timer;

    // Timer counts down to zero; chain saturates at 3 and drops on expiry.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
            chain <= '0;
        end else if (clear) begin
            timer <= '0;
            chain <= '0;
        end else if (load) begin
            timer <= POWER_CYCLES;
            chain <= '0;
        end else begin
            if (timer != '0) begin
                timer <= timer - 24'd1;
            end
            if (timer == 24'd1) begin
                chain <= '0;
            end else if (ghost_inc && (chain != 2'd3)) begin
                chain <= chain + 2'd1;
            end
        end
    end

    assign power_active = (timer != '0);

endmodule

// File: rtl/pill_event_scheduler.sv
// Turns edge-detected collision codes into one-cycle score/pill/hit pulses,
// tracks level progress and buffers one event that arrives mid-issue.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; issues the pending event first, else a new event
// ST_ISSUE | output pulses valid for this single cycle
// ST_DONE  | all pills eaten; events ignored until level_restart
module pill_event_scheduler
    import pill_event_scheduler_pkg::*;
#(
    parameter logic [7:0]  TOTAL_PILLS  = 8'd150,
    parameter logic [23:0] POWER_CYCLES = 24'd10_000_000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    pill_event_scheduler_if.slave        bus
);

    state_t      state;
    logic [3:0]  col_q;
    logic        is_event;
    logic        pend_v;
    logic [3:0]  pend_code;
    logic        issue_go;
    logic [3:0]  issue_code;
    logic        pt_load;
    logic        pt_ghost;
    logic        power_active;
    logic [1:0]  chain;

    logic        pill_inc;
    logic        score_valid;
    logic [11:0] score_add;
    logic        pacman_hit;
    logic [7:0]  pill_count;
    logic        level_done;
    logic        overflow;

    // A held code is one event: only a change to a valid code counts.
    assign is_event = col_valid(bus.collision_type) && (bus.collision_type != col_q);

    // Select what IDLE issues this edge; a pending event always goes first.
    always_comb begin
        issue_go   = 1'b0;
        issue_code = bus.collision_type;
        if ((state == ST_IDLE) && !bus.level_restart) begin
            if (pend_v) begin
                issue_go   = 1'b1;
                issue_code = pend_code;
            end else if (is_event) begin
                issue_go = 1'b1;
            end
        end
    end

    assign pt_load  = issue_go && (issue_code == COL_POWER);
    assign pt_ghost = issue_go && (issue_code == COL_GHOST) && power_active;

    power_timer #(
        .POWER_CYCLES (POWER_CYCLES)
    ) u_power_timer (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .clear        (bus.level_restart),
        .load         (pt_load),
        .ghost_inc    (pt_ghost),
        .power_active (power_active),
        .chain        (chain)
    );

    // Scheduler FSM with registered pulse outputs, pending slot and level count.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            col_q       <= 4'b0000;
            pend_v      <= 1'b0;
            pend_code   <= 4'b0000;
            pill_inc    <= 1'b0;
            score_valid <= 1'b0;
            score_add   <= '0;
            pacman_hit  <= 1'b0;
            pill_count  <= '0;
            level_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            col_q       <= bus.collision_type;
            pill_inc    <= 1'b0;
            score_valid <= 1'b0;
            score_add   <= '0;
            pacman_hit  <= 1'b0;
            if (bus.level_restart) begin
                state      <= ST_IDLE;
                pend_v     <= 1'b0;
                pill_count <= '0;
                level_done <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (issue_go) begin
                            state <= ST_ISSUE;
                            case (issue_code)
                                COL_PILL, COL_POWER: begin
                                    pill_inc    <= 1'b1;
                                    score_valid <= 1'b1;
                                    score_add   <= (issue_code == COL_PILL) ? PTS_PILL : PTS_POWER;
                                    if (pill_count < TOTAL_PILLS) begin
                                        pill_count <= pill_count + 8'd1;
                                    end
                                end
                                COL_GHOST: begin
                                    if (power_active) begin
                                        score_valid <= 1'b1;
                                        score_add   <= ghost_points(chain);
                                    end else begin
                                        pacman_hit <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        // The slot is being drained this edge, so a new event
                        // arriving now has nowhere to go.
                        if (pend_v) begin
                            pend_v <= 1'b0;
                            if (is_event) begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (is_event) begin
                            if (pend_v) begin
                                overflow <= 1'b1;
                            end else begin
                                pend_v    <= 1'b1;
                                pend_code <= bus.collision_type;
                            end
                        end
                        if (pill_count == TOTAL_PILLS) begin
                            state      <= ST_DONE;
                            level_done <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        level_done <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pill_inc     = pill_inc;
    assign bus.score_valid  = score_valid;
    assign bus.score_add    = score_add;
    assign bus.power_active = power_active;
    assign bus.pacman_hit   = pacman_hit;
    assign bus.pill_count   = pill_count;
    assign bus.level_done   = level_done;
    assign bus.overflow     = overflow;

endmodule

// File: tb/tb_pill_event_scheduler.sv
// Directed, table-driven bench for pill_event_scheduler with a short level
// (3 pills) and a short power period (16 clocks).
module tb_pill_event_scheduler;

    logic CLOCK_50;
    logic reset_n;
    int   errors;
    int   checks;

    pill_event_scheduler_if bus ();

    pill_event_scheduler #(
        .TOTAL_PILLS  (8'd3),
        .POWER_CYCLES (24'd16)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [3:0]  col;
        logic        rr;
        logic        pinc;
        logic        sv;
        logic [11:0] sadd;
        logic        hit;
        logic        pwr;
        logic [7:0]  cnt;
        logic        done;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] col, input logic rr, input logic pinc,
                           input logic sv, input logic [11:0] sadd, input logic hit,
                           input logic pwr, input logic [7:0] cnt, input logic done,
                           input logic ovf);
        vec_t v;
        v.col = col; v.rr = rr; v.pinc = pinc; v.sv = sv; v.sadd = sadd;
        v.hit = hit; v.pwr = pwr; v.cnt = cnt; v.done = done; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    function automatic logic [25:0] pack_exp(input logic pinc, input logic sv,
                                             input logic [11:0] sadd, input logic hit,
                                             input logic pwr, input logic [7:0] cnt,
                                             input logic done, input logic ovf);
        return {pinc, sv, sadd, hit, pwr, cnt, done, ovf};
    endfunction

    function automatic logic [25:0] pack_act();
        return {bus.pill_inc, bus.score_valid, bus.score_add, bus.pacman_hit,
                bus.power_active, bus.pill_count, bus.level_done, bus.overflow};
    endfunction

    task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {pinc,sv,add,hit,pwr,cnt,done,ovf}=%h expected %h",
                     name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        bus.collision_type = 4'b0000;
        bus.level_restart  = 1'b0;

        //       col     rr  pinc sv  add       hit pwr cnt  done ovf
        // single pill, code held for four cycles
        add_vec(4'b0010, 0, 1, 1, 12'd10,   0, 0, 8'd1, 0, 0);
        add_vec(4'b0010, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 0);
        add_vec(4'b0010, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 0);
        add_vec(4'b0010, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 0);
        add_vec(4'b0000, 1, 0, 0, 12'd0,    0, 0, 8'd0, 0, 0);
        // pellet then two ghosts during power
        add_vec(4'b0110, 0, 1, 1, 12'd50,   0, 1, 8'd1, 0, 0);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd1, 0, 0);
        add_vec(4'b0100, 0, 0, 1, 12'd200,  0, 1, 8'd1, 0, 0);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd1, 0, 0);
        add_vec(4'b0100, 0, 0, 1, 12'd400,  0, 1, 8'd1, 0, 0);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd1, 0, 0);
        // timer loaded with 16 at the pellet edge, 11 left here: 10 more high, then low
        for (int i = 0; i < 10; i++) begin
            add_vec(4'b0000, 0, 0, 0, 12'd0, 0, 1, 8'd1, 0, 0);
        end
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 0);
        // ghost outside power, then new pellet restarts chain at 200
        add_vec(4'b0100, 0, 0, 0, 12'd0,    1, 0, 8'd1, 0, 0);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 0);
        add_vec(4'b0110, 0, 1, 1, 12'd50,   0, 1, 8'd2, 0, 0);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 0);
        add_vec(4'b0100, 0, 0, 1, 12'd200,  0, 1, 8'd2, 0, 0);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 0);
        add_vec(4'b0000, 1, 0, 0, 12'd0,    0, 0, 8'd0, 0, 0);
        // back-to-back events: third one dropped
        add_vec(4'b0010, 0, 1, 1, 12'd10,   0, 0, 8'd1, 0, 0);
        add_vec(4'b0110, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 0);
        add_vec(4'b0010, 0, 1, 1, 12'd50,   0, 1, 8'd2, 0, 1);
        add_vec(4'b0010, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 1, 0, 0, 12'd0,    0, 0, 8'd0, 0, 1);
        // three pills complete the level
        add_vec(4'b0010, 0, 1, 1, 12'd10,   0, 0, 8'd1, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 1);
        add_vec(4'b0010, 0, 1, 1, 12'd10,   0, 0, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 0, 8'd2, 0, 1);
        add_vec(4'b0010, 0, 1, 1, 12'd10,   0, 0, 8'd3, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 0, 8'd3, 1, 1);
        add_vec(4'b0010, 0, 0, 0, 12'd0,    0, 0, 8'd3, 1, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 0, 8'd3, 1, 1);
        add_vec(4'b0110, 0, 0, 0, 12'd0,    0, 0, 8'd3, 1, 1);
        add_vec(4'b0000, 1, 0, 0, 12'd0,    0, 0, 8'd0, 0, 1);
        add_vec(4'b0010, 0, 1, 1, 12'd10,   0, 0, 8'd1, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 0, 8'd1, 0, 1);
        // ghost chain saturates at 1600
        add_vec(4'b0110, 0, 1, 1, 12'd50,   0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);
        add_vec(4'b0100, 0, 0, 1, 12'd200,  0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);
        add_vec(4'b0100, 0, 0, 1, 12'd400,  0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);
        add_vec(4'b0100, 0, 0, 1, 12'd800,  0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);
        add_vec(4'b0100, 0, 0, 1, 12'd1600, 0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);
        add_vec(4'b0100, 0, 0, 1, 12'd1600, 0, 1, 8'd2, 0, 1);
        add_vec(4'b0000, 0, 0, 0, 12'd0,    0, 1, 8'd2, 0, 1);

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_state", pack_act(), pack_exp(0, 0, 12'd0, 0, 0, 8'd0, 0, 0));
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLOCK_50);
            bus.collision_type = vecs[i].col;
            bus.level_restart  = vecs[i].rr;
            @(posedge CLOCK_50);
            #1;
            chk($sformatf("row%0d", i), pack_act(),
                pack_exp(vecs[i].pinc, vecs[i].sv, vecs[i].sadd, vecs[i].hit,
                         vecs[i].pwr, vecs[i].cnt, vecs[i].done, vecs[i].ovf));
        end

        // Reset asserted while a pill pulse is on the outputs.
        @(negedge CLOCK_50);
        bus.collision_type = 4'b0010;
        bus.level_restart  = 1'b0;
        @(posedge CLOCK_50);
        #1;
        chk("issue_before_reset", pack_act(), pack_exp(1, 1, 12'd10, 0, 1, 8'd3, 0, 1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_issue", pack_act(), pack_exp(0, 0, 12'd0, 0, 0, 8'd0, 0, 0));

        // Release with a valid code held: the first edge sees it as an event.
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("release_valid_code", pack_act(), pack_exp(1, 1, 12'd10, 0, 0, 8'd1, 0, 0));

        // Release with code 0000: nothing happens.
        @(negedge CLOCK_50);
        bus.collision_type = 4'b0000;
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("release_zero_code", pack_act(), pack_exp(0, 0, 12'd0, 0, 0, 8'd0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pill_event_scheduler.md
PILL_EVENT_SCHEDULER -- requirements
Module: pill_event_scheduler

Interface
REQ-001 Parameter TOTAL_PILLS, default 8'd150, pill count that completes the level.
REQ-002 Parameter POWER_CYCLES, default 24'd10_000_000, power-mode duration in clocks.
REQ-003 CLOCK_50  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 collision_type  input  4  level code from collision detector (0010 pill, 0110 power pellet, 0100 ghost, else none).
REQ-006 level_restart  input  1  one-cycle pulse; clears pill count and DONE state.
REQ-007 pill_inc  output  1  one-cycle pulse per accepted pill or power pellet, drives pill counter increment.
REQ-008 score_valid  output  1  one-cycle pulse qualifying score_add.
REQ-009 score_add  output  12  points to add while score_valid is high, else 0.
REQ-010 power_active  output  1  high while power timer is nonzero.
REQ-011 pacman_hit  output  1  one-cycle pulse on ghost collision outside power mode.
REQ-012 pill_count  output  8  pills and pellets consumed this level.
REQ-013 level_done  output  1  high in DONE state.
REQ-014 overflow  output  1  sticky; set when an event is dropped.

Function
REQ-015 Event detect: an event SHALL be a cycle where collision_type is a valid code and differs from its value registered the previous cycle; a held code SHALL produce one event only.
REQ-016 FSM states SHALL be IDLE, ISSUE, DONE; reset state IDLE.
REQ-017 IDLE: on event (or with pending event valid) -> ISSUE, latching the event type; pending consumed first.
REQ-018 ISSUE: outputs asserted for exactly this one cycle, then -> DONE if pill_count == TOTAL_PILLS after the update, else IDLE.
REQ-019 Latency: event sampled at edge N SHALL produce pulses in the cycle after edge N.
REQ-020 One-deep pending register SHALL hold an event arriving while in ISSUE; a further event while pending is full SHALL be dropped and set overflow.
REQ-021 Pill: pill_inc=1, score_add=10, pill_count+1.
REQ-022 Power pellet: pill_inc=1, score_add=50, pill_count+1, power timer loaded to POWER_CYCLES (reload if already active), ghost chain reset to 0.
REQ-023 Ghost with power_active: score_add = 200 << chain (200/400/800/1600), chain increments, saturates at 3; pill_count unchanged.
REQ-024 Ghost without power_active: pacman_hit=1, score_valid=0, no count change.
REQ-025 Power timer SHALL decrement by 1 per clock when nonzero; power_active = (timer != 0); chain SHALL clear when timer reaches 0.
REQ-026 pill_count SHALL never exceed TOTAL_PILLS; no wrap.
REQ-027 DONE: all events ignored (not pended, no overflow); level_done=1; level_restart -> IDLE, pill_count=0, pending cleared, timer and chain cleared.
REQ-028 level_restart in IDLE or ISSUE SHALL clear pill_count, pending, timer, chain and go IDLE; it takes precedence over a same-cycle event.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, all outputs 0, pill_count 0, timer 0, chain 0, pending empty, overflow 0, registered collision_type 4'b0000.
REQ-030 Reset assertion mid-ISSUE SHALL abort the pulse with no count update; release SHALL be synchronous-safe (no event on first edge unless collision_type valid and nonzero).

Structure
REQ-031 Shared package SHALL hold collision codes (COL_PILL, COL_POWER, COL_GHOST), point constants (10, 50, 200) and the FSM state enum.
REQ-032 Power timer and ghost chain SHALL be one sub-module, power_timer.

Verification
REQ-033 Reset, collision_type 0010 held 4 cycles -> one pill_inc, score_add=10, pill_count=1.
REQ-034 0110 then 0100 twice (distinct edges) during power -> scores 50, 200, 400; power_active high; pill_count=1.
REQ-035 0100 with power inactive -> pacman_hit pulse, score_valid 0; power expiry after POWER_CYCLES (bench 16) -> power_active 0, next ghost scores 200 again only after new pellet.
REQ-036 Events 0010,0110,0010 on three consecutive cycles -> first two issued, third dropped, overflow=1.
REQ-037 TOTAL_PILLS=3, three pills -> level_done=1; further pill ignored, count stays 3; level_restart -> count 0, IDLE.
REQ-038 reset_n pulled low during ISSUE -> outputs 0 asynchronously, pill_count 0.
